// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, access-size encodings and the
// data-memory write-buffer record.
package riscv_pkg;

  localparam int XLEN = 32;

  // One-hot access sizes driven by the core on its data port
  localparam logic [2:0] ACC_BYTE = 3'b001;
  localparam logic [2:0] ACC_HALF = 3'b010;
  localparam logic [2:0] ACC_WORD = 3'b100;

  // Posted store: word index, byte-lane enables and lane-aligned data.
  // The index keeps every address bit above the byte offset so that
  // forwarding compares the full word address.
  typedef struct packed {
    logic [XLEN-3:0] idx;
    logic [3:0]      mask;
    logic [XLEN-1:0] data;
  } wbuf_t;

  // Byte lanes touched by an access of the given size at the given offset
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      ACC_BYTE: m = 4'b0001 << off;
      ACC_HALF: m = 4'b0011 << off;
      ACC_WORD: m = 4'b1111;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  // Right-aligned result mask for a load of the given size
  function automatic logic [XLEN-1:0] result_mask(input logic [2:0] size);
    logic [XLEN-1:0] m;
    m = '0;
    case (size)
      ACC_BYTE: m = XLEN'(32'h0000_00FF);
      ACC_HALF: m = XLEN'(32'h0000_FFFF);
      ACC_WORD: m = '1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage for data_mem: asynchronous read port and a
// synchronous write port with per-byte enables. Contents are not reset.
module data_mem_array
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [3:0]       wbe_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [XLEN-1:0]  rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  // Byte-enabled write of the draining store
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: same-cycle loads, stores posted through a
// one-entry write buffer that drains on the next edge, loads forward
// from that buffer, and bad accesses are reported on a registered port.
module data_mem
  import riscv_pkg::*;
#(
  parameter int              DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADR    = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            err_q_o,
  output logic [XLEN-1:0] err_adr_q_o,
  output logic            wbuf_v_q_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [XLEN-1:0] rel_adr;
  logic [XLEN-1:0] idx_ext;
  logic [1:0]      off;
  logic            reject;
  logic            access_ok;
  logic [3:0]      acc_mask;
  logic [XLEN-1:0] lane_data;

  wbuf_t           wbuf_q, wbuf_d;
  logic            wbuf_v_q, wbuf_v_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] err_adr_q, err_adr_d;

  logic [XLEN-1:0] raw_word;
  logic [XLEN-1:0] merged_word;
  logic            fwd_hit;

  // Address decode and legality check; anything out of range, misaligned
  // or with a non-one-hot size is rejected outright
  always_comb begin
    rel_adr   = adr_i - BASE_ADR;
    idx_ext   = rel_adr >> 2;
    off       = adr_i[1:0];
    reject    = 1'b0;
    if (idx_ext >= XLEN'(DEPTH_WORDS)) begin
      reject = 1'b1;
    end
    if (!(access_size_i == ACC_BYTE || access_size_i == ACC_HALF ||
          access_size_i == ACC_WORD)) begin
      reject = 1'b1;
    end
    if (access_size_i == ACC_HALF && off[0]) begin
      reject = 1'b1;
    end
    if (access_size_i == ACC_WORD && off != 2'b00) begin
      reject = 1'b1;
    end
    access_ok = adr_v_i & ~reject;
    acc_mask  = lane_mask(access_size_i, off);
    lane_data = store_data_i << {off, 3'b000};
  end

  // Next write-buffer state: capture an accepted store, otherwise let the
  // buffer empty since its content drains on this edge regardless
  always_comb begin
    wbuf_d   = wbuf_q;
    wbuf_v_d = 1'b0;
    if (access_ok && is_store_i) begin
      wbuf_d.idx  = idx_ext[XLEN-3:0];
      wbuf_d.mask = acc_mask;
      wbuf_d.data = lane_data;
      wbuf_v_d    = 1'b1;
    end
  end

  // Error reporting: pulse for each rejected access, remember its address
  always_comb begin
    err_d     = adr_v_i & reject;
    err_adr_d = err_adr_q;
    if (adr_v_i && reject) begin
      err_adr_d = adr_i;
    end
  end

  // Buffer and error registers; a pending store is dropped by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbuf_q    <= '0;
      wbuf_v_q  <= 1'b0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      wbuf_q    <= wbuf_d;
      wbuf_v_q  <= wbuf_v_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (wbuf_v_q),
    .waddr_i (wbuf_q.idx[IDX_W-1:0]),
    .wbe_i   (wbuf_q.mask),
    .wdata_i (wbuf_q.data),
    .raddr_i (idx_ext[IDX_W-1:0]),
    .rdata_o (raw_word)
  );

  // Load path: overlay buffered bytes on the array word, then right-align
  // and trim to the access size; non-loads and rejects return zero
  always_comb begin
    fwd_hit     = wbuf_v_q && (wbuf_q.idx == idx_ext[XLEN-3:0]);
    merged_word = raw_word;
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit && wbuf_q.mask[i]) begin
        merged_word[8*i +: 8] = wbuf_q.data[8*i +: 8];
      end
    end
    load_data_o = '0;
    if (access_ok && !is_store_i) begin
      load_data_o = (merged_word >> {off, 3'b000}) & result_mask(access_size_i);
    end
  end

  assign err_q_o     = err_q;
  assign err_adr_q_o = err_adr_q;
  assign wbuf_v_q_o  = wbuf_v_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, a reset-while-
// pending sequence, and randomized traffic against a byte-level model.
module tb_data_mem;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        adr_v_i;
  logic [31:0] adr_i;
  logic        is_store_i;
  logic [31:0] store_data_i;
  logic [2:0]  access_size_i;
  logic [31:0] load_data_o;
  logic        err_q_o;
  logic [31:0] err_adr_q_o;
  logic        wbuf_v_q_o;

  int checks   = 0;
  int failures = 0;

  // Byte-addressed model: a store is simply visible from the next cycle on
  logic [7:0]  model_mem   [4*DEPTH];
  bit          model_known [4*DEPTH];
  logic [31:0] model_err_adr;

  typedef struct packed {
    logic        v;
    logic [31:0] adr;
    logic        st;
    logic [31:0] data;
    logic [2:0]  size;
    logic [31:0] exp_load;
    logic        exp_err;
    logic [31:0] exp_err_adr;
    logic        exp_wbuf;
  } vec_t;

  vec_t vecs [20];

  data_mem #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADR    (BASE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adr_v_i       (adr_v_i),
    .adr_i         (adr_i),
    .is_store_i    (is_store_i),
    .store_data_i  (store_data_i),
    .access_size_i (access_size_i),
    .load_data_o   (load_data_o),
    .err_q_o       (err_q_o),
    .err_adr_q_o   (err_adr_q_o),
    .wbuf_v_q_o    (wbuf_v_q_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(input logic v, input logic [31:0] adr,
                                 input logic st, input logic [31:0] data,
                                 input logic [2:0] size, input logic [31:0] exp_load,
                                 input logic exp_err, input logic [31:0] exp_err_adr,
                                 input logic exp_wbuf);
    vec_t r;
    r.v = v; r.adr = adr; r.st = st; r.data = data; r.size = size;
    r.exp_load = exp_load; r.exp_err = exp_err; r.exp_err_adr = exp_err_adr;
    r.exp_wbuf = exp_wbuf;
    return r;
  endfunction

  function automatic bit isBad(input logic [31:0] adr, input logic [2:0] size);
    logic [31:0] rel;
    rel = adr - BASE;
    if (!(size == 3'd1 || size == 3'd2 || size == 3'd4)) return 1'b1;
    if (rel >= 32'(4*DEPTH)) return 1'b1;
    if (size == 3'd2 && (adr % 2) != 0) return 1'b1;
    if (size == 3'd4 && (adr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sizeBytes(input logic [2:0] size);
    return (size == 3'd1) ? 1 : (size == 3'd2) ? 2 : 4;
  endfunction

  task automatic modelLoad(input logic [31:0] adr, input logic [2:0] size,
                           output logic [31:0] val, output bit known);
    int unsigned rel;
    rel   = adr - BASE;
    val   = 32'h0;
    known = 1'b1;
    for (int k = 0; k < sizeBytes(size); k++) begin
      val   = val | ({24'h0, model_mem[rel+k]} << (8*k));
      known = known & model_known[rel+k];
    end
  endtask

  task automatic modelCommit(input logic v, input logic [31:0] adr, input logic st,
                             input logic [31:0] data, input logic [2:0] size);
    int unsigned rel;
    if (!v) return;
    if (isBad(adr, size)) begin
      model_err_adr = adr;
      return;
    end
    if (st) begin
      rel = adr - BASE;
      for (int k = 0; k < sizeBytes(size); k++) begin
        model_mem[rel+k]   = data[8*k +: 8];
        model_known[rel+k] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // One access cycle: load data is checked before the edge, registered
  // outputs just after it
  task automatic applyStimulus(input logic v, input logic [31:0] adr, input logic st,
                               input logic [31:0] data, input logic [2:0] size,
                               input logic [31:0] exp_load, input bit chk_load,
                               input logic exp_err, input logic [31:0] exp_err_adr,
                               input logic exp_wbuf, input string tag);
    adr_v_i       = v;
    adr_i         = adr;
    is_store_i    = st;
    store_data_i  = data;
    access_size_i = size;
    @(negedge clk);
    if (chk_load) checkOutput({tag, "_load"}, load_data_o, exp_load);
    @(posedge clk);
    #1;
    checkOutput({tag, "_err"}, {31'h0, err_q_o}, {31'h0, exp_err});
    checkOutput({tag, "_err_adr"}, err_adr_q_o, exp_err_adr);
    checkOutput({tag, "_wbuf_v"}, {31'h0, wbuf_v_q_o}, {31'h0, exp_wbuf});
  endtask

  // Model-driven cycle used by the init pass and the random phase
  task automatic modelCycle(input logic v, input logic [31:0] adr, input logic st,
                            input logic [31:0] data, input logic [2:0] size,
                            input string tag);
    logic [31:0] exp_load;
    bit          known;
    bit          bad;
    logic [31:0] exp_eadr;
    bad      = v && isBad(adr, size);
    exp_eadr = bad ? adr : model_err_adr;
    exp_load = 32'h0;
    known    = 1'b1;
    if (v && !st && !bad) modelLoad(adr, size, exp_load, known);
    applyStimulus(v, adr, st, data, size, exp_load, known, bad, exp_eadr,
                  v && st && !bad, tag);
    modelCommit(v, adr, st, data, size);
  endtask

  initial begin
    logic [2:0]  size_pool [14];
    logic [31:0] radr;
    logic [2:0]  rsize;
    int          sel;

    size_pool = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4,
                  3'd3, 3'd0, 3'd7, 3'd5, 3'd6};
    for (int i = 0; i < 4*DEPTH; i++) begin
      model_mem[i]   = 8'h00;
      model_known[i] = 1'b0;
    end
    model_err_adr = 32'h0;

    adr_v_i = 1'b0; adr_i = 32'h0; is_store_i = 1'b0;
    store_data_i = 32'h0; access_size_i = 3'b100;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset_wbuf_v", {31'h0, wbuf_v_q_o}, 32'h0);
    checkOutput("reset_err", {31'h0, err_q_o}, 32'h0);
    checkOutput("reset_err_adr", err_adr_q_o, 32'h0);
    checkOutput("reset_load", load_data_o, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Directed table: one row per cycle, constants worked out by hand
    vecs[0]  = mkVec(1, 32'h3FFC, 1, 32'hCAFEF00D, 3'b100, 32'h0,        0, 32'h0,    1);
    vecs[1]  = mkVec(1, 32'h0060, 1, 32'h01020304, 3'b100, 32'h0,        0, 32'h0,    1);
    vecs[2]  = mkVec(1, 32'h0010, 1, 32'hDEADBEEF, 3'b100, 32'h0,        0, 32'h0,    1);
    vecs[3]  = mkVec(0, 32'h0000, 0, 32'h0,        3'b100, 32'h0,        0, 32'h0,    0);
    vecs[4]  = mkVec(1, 32'h0010, 0, 32'h0,        3'b100, 32'hDEADBEEF, 0, 32'h0,    0);
    vecs[5]  = mkVec(1, 32'h0020, 1, 32'h11223344, 3'b100, 32'h0,        0, 32'h0,    1);
    vecs[6]  = mkVec(1, 32'h0023, 0, 32'h0,        3'b001, 32'h00000011, 0, 32'h0,    0);
    vecs[7]  = mkVec(1, 32'h0022, 0, 32'h0,        3'b010, 32'h00001122, 0, 32'h0,    0);
    vecs[8]  = mkVec(1, 32'h0030, 1, 32'hAAAAAAAA, 3'b100, 32'h0,        0, 32'h0,    1);
    vecs[9]  = mkVec(1, 32'h0031, 1, 32'h00000055, 3'b001, 32'h0,        0, 32'h0,    1);
    vecs[10] = mkVec(1, 32'h0030, 0, 32'h0,        3'b100, 32'hAAAA55AA, 0, 32'h0,    0);
    vecs[11] = mkVec(1, 32'h0041, 0, 32'h0,        3'b010, 32'h0,        1, 32'h41,   0);
    vecs[12] = mkVec(1, 32'h4000, 1, 32'h12345678, 3'b100, 32'h0,        1, 32'h4000, 0);
    vecs[13] = mkVec(1, 32'h3FFC, 0, 32'h0,        3'b100, 32'hCAFEF00D, 0, 32'h4000, 0);
    vecs[14] = mkVec(1, 32'h0060, 1, 32'h99999999, 3'b011, 32'h0,        1, 32'h60,   0);
    vecs[15] = mkVec(1, 32'h0060, 0, 32'h0,        3'b100, 32'h01020304, 0, 32'h60,   0);
    vecs[16] = mkVec(1, 32'h0013, 1, 32'h00000077, 3'b001, 32'h0,        0, 32'h60,   1);
    vecs[17] = mkVec(1, 32'h0010, 0, 32'h0,        3'b100, 32'h77ADBEEF, 0, 32'h60,   0);
    vecs[18] = mkVec(1, 32'h0012, 0, 32'h0,        3'b001, 32'h000000AD, 0, 32'h60,   0);
    vecs[19] = mkVec(0, 32'h0010, 0, 32'h0,        3'b100, 32'h0,        0, 32'h60,   0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].v, vecs[i].adr, vecs[i].st, vecs[i].data, vecs[i].size,
                    vecs[i].exp_load, 1'b1, vecs[i].exp_err, vecs[i].exp_err_adr,
                    vecs[i].exp_wbuf, $sformatf("vec%0d", i));
      modelCommit(vecs[i].v, vecs[i].adr, vecs[i].st, vecs[i].data, vecs[i].size);
    end

    // Reset while a store is still buffered: that store must be lost
    modelCycle(1, 32'h50, 1, 32'h5A5A5A5A, 3'b100, "rst_pre");
    modelCycle(0, 32'h0, 0, 32'h0, 3'b100, "rst_idle");
    applyStimulus(1, 32'h50, 1, 32'h0BADF00D, 3'b100, 32'h0, 1'b1, 1'b0,
                  model_err_adr, 1'b1, "rst_store");
    adr_v_i = 1'b0; is_store_i = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_wbuf_v", {31'h0, wbuf_v_q_o}, 32'h0);
    checkOutput("rst_mid_err", {31'h0, err_q_o}, 32'h0);
    checkOutput("rst_mid_err_adr", err_adr_q_o, 32'h0);
    checkOutput("rst_mid_load", load_data_o, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_err_adr = 32'h0;
    applyStimulus(1, 32'h50, 0, 32'h0, 3'b100, 32'h5A5A5A5A, 1'b1, 1'b0,
                  32'h0, 1'b0, "rst_post_load");

    // Fill the random region so every later load has defined content
    for (int w = 0; w < 32; w++)
      modelCycle(1, BASE + 32'(4*w), 1, $urandom, 3'b100, "init_lo");
    for (int w = DEPTH-4; w < DEPTH; w++)
      modelCycle(1, BASE + 32'(4*w), 1, $urandom, 3'b100, "init_hi");

    // Random traffic near both ends of the array plus stray addresses
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       radr = BASE + 32'($urandom_range(0, 127));
      else if (sel < 9)  radr = BASE + 32'(4*DEPTH - 16 + $urandom_range(0, 23));
      else               radr = $urandom;
      rsize = size_pool[$urandom_range(0, 13)];
      modelCycle($urandom_range(0, 9) != 0, radr, 1'($urandom_range(0, 1)),
                 $urandom, rsize, $sformatf("rnd%0d", n));
    end

    adr_v_i = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder for the core's data port: accepts one load or store per cycle and returns load data in the same cycle. Sits outside the core, on the other end of its address/store/load interface. Stores are posted through a one-entry write buffer that drains into a word-addressed array on the following edge; loads forward from that buffer. Misaligned, out-of-range and bad-size accesses are rejected and reported on a registered error port.

## Interface
- XLEN, 32, data/address width (from riscv_pkg)
- DEPTH_WORDS, 4096, array depth in 32-bit words
- BASE_ADR, 32'h0000_0000, byte address of word 0
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- adr_v_i  in  1  access valid this cycle
- adr_i  in  XLEN  byte address
- is_store_i  in  1  1 = store, 0 = load (qualified by adr_v_i)
- store_data_i  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0])
- access_size_i  in  3  one-hot: ACC_BYTE=3'b001, ACC_HALF=3'b010, ACC_WORD=3'b100
- load_data_o  out  XLEN  combinational load data, right-aligned, upper bits zero; core performs sign/zero extension
- err_q_o  out  1  one-cycle pulse, the cycle after a rejected access
- err_adr_q_o  out  XLEN  address of the most recent rejected access (held)
- wbuf_v_q_o  out  1  write buffer holds an undrained store

## Operation
- Word index: idx = (adr_i - BASE_ADR) >> 2; offset off = adr_i[1:0].
- Reject conditions (any one): idx >= DEPTH_WORDS; ACC_HALF with off[0]=1; ACC_WORD with off!=0; access_size_i not one-hot.
- Byte mask: byte -> 4'b0001<<off, half -> 4'b0011<<off, word -> 4'b1111. Lane data: store_data_i << (8*off).
- Accepted store: at the edge, buffer <= {idx, mask, lane data} and wbuf_v_q <= 1. If the buffer was valid at the same edge, its old content is written to the array on that same edge. Therefore every buffered store drains exactly one edge after capture.
- Buffer with no new store: drains at the edge and wbuf_v_q <= 0.
- Load: raw = array[idx], with each byte i replaced by the buffer byte when wbuf_v_q & buf_idx==idx & mask[i]. Output is (raw >> 8*off) masked to the access size.
- load_data_o = 0 when adr_v_i=0, is_store_i=1 or the access is rejected.
- Rejected access: store not captured (an existing buffer still drains); err_q_o <= 1 for one cycle; err_adr_q_o <= adr_i.
- Array is not reset; content is undefined until written.

## Timing
- Reset values: wbuf_v_q_o=0, err_q_o=0, err_adr_q_o=0. Buffer index, mask and data are reset to 0.
- Reset asserted while wbuf_v_q=1: the pending store is discarded and never reaches the array.
- Load latency: 0 cycles (combinational from adr_i, access_size_i and buffer state).
- Store visibility: a load in cycle N+1 to a store accepted in cycle N is served by forwarding. From cycle N+2 it is served by the array.
- Back-to-back stores to the same word at cycles N and N+1: the N+1 capture and the N drain occur on the same edge. A load at N+2 sees both stores, with the N+1 bytes winning on overlap.
- Throughput: one access per cycle, no stall or back-pressure.
- err_q_o asserts in the cycle after the bad access and drops after one cycle. Consecutive bad accesses produce a continuous high, and err_adr_q_o updates every cycle.

## Structure
- riscv_pkg gains ACC_BYTE/ACC_HALF/ACC_WORD constants and a wbuf_t packed struct {idx, mask[3:0], data[XLEN-1:0]}. XLEN is already in riscv_pkg.
- One sub-module, data_mem_array: DEPTH_WORDS x 32 with asynchronous read and synchronous per-byte-enable write.
- The top level holds the decode/check logic, the write buffer, forwarding, extraction and error registers.

## Test plan
- Word store 0xDEADBEEF to 0x10, idle, word load 0x10 -> 0xDEADBEEF; wbuf_v_q_o high exactly one cycle.
- Word store 0x11223344 to 0x20, then byte load 0x23 in the next cycle (forward path) -> 0x00000011; half load 0x22 at N+2 -> 0x00001122.
- Back-to-back: word store 0xAAAAAAAA to 0x30, then byte store 0x55 to 0x31, then word load 0x30 -> 0xAAAA55AA.
- Half load at 0x41 -> load_data_o=0, err_q_o pulses one cycle later, err_adr_q_o=0x41. Word store to BASE_ADR+4*DEPTH_WORDS -> store dropped, error pulse, and a later load to that word's last valid neighbour is unchanged.
- access_size_i=3'b011 store -> rejected with error pulse; store_data is not written.
- Store to 0x50 followed immediately by reset_n low for one cycle, then word load 0x50 -> previous content of 0x50 (pending store lost); all outputs 0 during reset.
